// File: rtl/rpn_engine.sv
// RPN calculator core: operand stack, ALU and two-state command sequencer.
// Define RPN_MUL_EN to implement opcode 11 (MUL); otherwise it reports illegal.
module rpn_engine #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [3:0]                   cmd_op,
  input  logic [WIDTH-1:0]             cmd_data,
  output logic [WIDTH-1:0]             top,
  output logic [WIDTH-1:0]             next,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         done,
  output logic [1:0]                   err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_EXEC = 1'b1;

  localparam logic [3:0] OP_PUSH  = 4'd0;
  localparam logic [3:0] OP_POP   = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_SLL   = 4'd4;
  localparam logic [3:0] OP_SRL   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_AND   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_NOR   = 4'd9;
  localparam logic [3:0] OP_XOR   = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;
  localparam logic [3:0] OP_SWAP  = 4'd12;
  localparam logic [3:0] OP_DUP   = 4'd13;
  localparam logic [3:0] OP_CLEAR = 4'd14;
  localparam logic [3:0] OP_RSVD  = 4'd15;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

  logic             state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt;

  logic [AW-1:0]    idx_t, idx_n, idx_p;
  logic [WIDTH-1:0] alu;
  logic [CW-1:0]    cnt_n;
  logic [1:0]       err_n;
  logic             we0, we1;
  logic [AW-1:0]    idx0, idx1;
  logic [WIDTH-1:0] d0, d1;

  // Index arithmetic wraps in AW bits, so count = DEPTH still maps to the last entry.
  assign idx_t = AW'(cnt - CW'(1));
  assign idx_n = AW'(cnt - CW'(2));
  assign idx_p = AW'(cnt);

  assign top       = (cnt != '0)      ? mem[idx_t] : '0;
  assign next      = (cnt > CW'(1))   ? mem[idx_n] : '0;
  assign count     = cnt;
  assign cmd_ready = (state == ST_IDLE) && !rst;

`ifdef RPN_MUL_EN
  localparam bit MUL_OK = 1'b1;
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{1'b0}}, next} * {{WIDTH{1'b0}}, top};
`else
  localparam bit MUL_OK = 1'b0;
`endif

  always_comb begin
    alu = '0;
    case (op_q)
      OP_ADD:  alu = next + top;
      OP_SUB:  alu = next - top;
      OP_SLL:  alu = (top >= WIDTH'(WIDTH)) ? '0 : (next << top);
      OP_SRL:  alu = (top >= WIDTH'(WIDTH)) ? '0 : (next >> top);
      OP_SLTU: alu[0] = (next < top);
      OP_AND:  alu = next & top;
      OP_OR:   alu = next | top;
      OP_NOR:  alu = ~(next | top);
      OP_XOR:  alu = next ^ top;
`ifdef RPN_MUL_EN
      OP_MUL:  alu = prod[WIDTH-1:0];
`endif
      default: alu = '0;
    endcase
  end

  // SWAP is the only command needing a second write port.
  always_comb begin
    err_n = ERR_OK;
    cnt_n = cnt;
    we0   = 1'b0;
    we1   = 1'b0;
    idx0  = idx_p;
    idx1  = idx_n;
    d0    = data_q;
    d1    = top;
    case (op_q)
      OP_PUSH: begin
        if (cnt == CW'(DEPTH)) err_n = ERR_OVER;
        else begin
          we0   = 1'b1;
          cnt_n = cnt + CW'(1);
        end
      end
      OP_POP: begin
        if (cnt == '0) err_n = ERR_UNDER;
        else cnt_n = cnt - CW'(1);
      end
      OP_SWAP: begin
        if (cnt < CW'(2)) err_n = ERR_UNDER;
        else begin
          we0  = 1'b1;
          idx0 = idx_t;
          d0   = next;
          we1  = 1'b1;
        end
      end
      OP_DUP: begin
        if (cnt == CW'(DEPTH)) err_n = ERR_OVER;
        else if (cnt == '0) err_n = ERR_UNDER;
        else begin
          we0   = 1'b1;
          d0    = top;
          cnt_n = cnt + CW'(1);
        end
      end
      OP_CLEAR: cnt_n = '0;
      OP_RSVD:  err_n = ERR_ILL;
      default: begin
        if (op_q == OP_MUL && !MUL_OK) err_n = ERR_ILL;
        else if (cnt < CW'(2)) err_n = ERR_UNDER;
        else begin
          we0   = 1'b1;
          idx0  = idx_n;
          d0    = alu;
          cnt_n = cnt - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      err    <= ERR_OK;
      op_q   <= '0;
      data_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            state  <= ST_EXEC;
          end
        end
        default: begin
          cnt   <= cnt_n;
          err   <= err_n;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == ST_EXEC) begin
      if (we0) mem[idx0] <= d0;
      if (we1) mem[idx1] <= d1;
    end
  end

endmodule

// File: tb/tb_rpn_engine.sv
// Scoreboard bench for rpn_engine (WIDTH 16, DEPTH 4); honours RPN_MUL_EN.
module tb_rpn_engine;

  typedef struct packed {
    logic        ok;
    logic [15:0] top;
    logic [15:0] next;
    logic [2:0]  count;
    logic [1:0]  err;
  } res_t;

`ifdef RPN_MUL_EN
  localparam bit MUL = 1'b1;
`else
  localparam bit MUL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [15:0] top;
  logic [15:0] next;
  logic [2:0]  count;
  logic        done;
  logic [1:0]  err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  res_t        exp_q[$];
  res_t        obs_q[$];
  logic [15:0] ms[$];

  rpn_engine #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .top(top), .next(next),
    .count(count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_push(input logic [3:0] op, input logic [15:0] d);
    res_t        e;
    logic [15:0] t, n, r;
    logic [31:0] p;
    int          sz;
    e = '0;
    e.ok = 1'b1;
    sz = ms.size();
    case (op)
      4'd0:  if (sz == 4) e.err = 2'b10; else ms.push_back(d);
      4'd1:  if (sz == 0) e.err = 2'b01; else void'(ms.pop_back());
      4'd12: if (sz < 2) e.err = 2'b01;
             else begin t = ms.pop_back(); n = ms.pop_back(); ms.push_back(t); ms.push_back(n); end
      4'd13: if (sz == 4) e.err = 2'b10; else if (sz == 0) e.err = 2'b01; else ms.push_back(ms[sz-1]);
      4'd14: ms.delete();
      4'd15: e.err = 2'b11;
      default: begin
        if (op == 4'd11 && !MUL) e.err = 2'b11;
        else if (sz < 2) e.err = 2'b01;
        else begin
          t = ms.pop_back();
          n = ms.pop_back();
          p = n * t;
          case (op)
            4'd2:  r = n + t;
            4'd3:  r = n - t;
            4'd4:  r = (t < 16) ? (n << t[3:0]) : 16'h0;
            4'd5:  r = (t < 16) ? (n >> t[3:0]) : 16'h0;
            4'd6:  r = (n < t) ? 16'h1 : 16'h0;
            4'd7:  r = n & t;
            4'd8:  r = n | t;
            4'd9:  r = ~(n | t);
            4'd10: r = n ^ t;
            default: r = p[15:0];
          endcase
          ms.push_back(r);
        end
      end
    endcase
    sz = ms.size();
    e.count = 3'(sz);
    e.top   = (sz > 0) ? ms[sz-1] : 16'h0;
    e.next  = (sz > 1) ? ms[sz-2] : 16'h0;
    exp_q.push_back(e);
  endtask

  // Drives one handshake, scrambles the command bus afterwards, captures the completion.
  task automatic send(input logic [3:0] op, input logic [15:0] d);
    res_t o;
    o = '0;
    @(negedge clk);
    for (int k = 0; k < 8 && !cmd_ready; k++) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    model_push(op, d);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 4'hF;
    cmd_data  = ~d;
    for (int k = 0; k < 8; k++) begin
      if (done) begin
        o.ok = 1'b1; o.top = top; o.next = next; o.count = count; o.err = err;
        break;
      end
      @(negedge clk);
    end
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    cmd_valid = 1'b0; cmd_op = 4'h0; cmd_data = 16'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (top !== 16'h0 || next !== 16'h0) begin n_bad++; $display("FAIL reset_top_next: got %h/%h want 0/0", top, next); end
    n_cmp++; if (done !== 1'b0 || err !== 2'b00) begin n_bad++; $display("FAIL reset_done_err: got %b/%b want 0/00", done, err); end
    rst = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b want 1", cmd_ready); end
    ms.delete();
  endtask

  task automatic test_add();
    res_t e, o;
    send(4'd0, 16'h0003);
    send(4'd0, 16'h0004);
    send(4'd2, 16'h0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL add: got %p want %p", o, e); end
    end
    n_cmp++; if (o.top !== 16'h0007 || o.count !== 3'd1) begin n_bad++; $display("FAIL add_result: got top=%h count=%0d want 0007/1", o.top, o.count); end
  endtask

  task automatic test_alu();
    res_t e, o;
    logic [3:0]  ops[20] = '{14, 0, 0, 3, 0, 4, 0, 6, 14, 0, 0, 7, 0, 8, 0, 9, 0, 10, 0, 0};
    logic [15:0] ds[20]  = '{0, 16'h1, 16'h3, 0, 16'h11, 0, 16'h2, 0, 0, 16'hF0F0, 16'h0FF0, 0,
                             16'h0F00, 0, 16'h000F, 0, 16'hFFFF, 0, 16'h1, 16'hF};
    logic [3:0]  ops2[5] = '{4, 0, 5, 0, 5};
    logic [15:0] ds2[5]  = '{0, 16'hF, 0, 16'h10, 0};
    for (int i = 0; i < 20; i++) send(ops[i], ds[i]);
    for (int i = 0; i < 5; i++) send(ops2[i], ds2[i]);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL alu: got %p want %p", o, e); end
    end
  endtask

  task automatic test_stack_ops();
    res_t e, o;
    logic [3:0]  ops[6] = '{14, 0, 0, 12, 13, 1};
    logic [15:0] ds[6]  = '{0, 16'h00AA, 16'h0055, 0, 0, 0};
    for (int i = 0; i < 6; i++) send(ops[i], ds[i]);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL stack_ops: got %p want %p", o, e); end
    end
  endtask

  task automatic test_bounds();
    res_t e, o;
    logic [3:0]  ops[13] = '{14, 0, 0, 0, 0, 0, 13, 14, 2, 1, 12, 13, 14};
    logic [15:0] ds[13]  = '{0, 16'h11, 16'h22, 16'h33, 16'h44, 16'h55, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 13; i++) send(ops[i], ds[i]);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL bounds: got %p want %p", o, e); end
    end
  endtask

  task automatic test_illegal_mul();
    res_t e, o;
    logic [3:0]  ops[6] = '{14, 0, 15, 0, 0, 11};
    logic [15:0] ds[6]  = '{0, 16'h0007, 16'h1234, 16'h0100, 16'h0100, 0};
    for (int i = 0; i < 6; i++) send(ops[i], ds[i]);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL illegal_mul: got %p want %p", o, e); end
    end
  endtask

  task automatic test_reset_exec();
    res_t e, o;
    int unsigned stray = 0;
    send(4'd0, 16'h1234);
    @(negedge clk);
    for (int k = 0; k < 8 && !cmd_ready; k++) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_data = 16'h5555;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_exec_done: got %b want 0", done); end
    n_cmp++; if (count !== 3'd0 || top !== 16'h0) begin n_bad++; $display("FAIL rst_exec_stack: got count=%0d top=%h want 0/0000", count, top); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_exec_ready: got %b want 0", cmd_ready); end
    rst = 1'b0;
    ms.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) stray++;
    end
    n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL rst_exec_stray_done: got %0d pulses want 0", stray); end
    send(4'd0, 16'h0009);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL rst_exec: got %p want %p", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    res_t        e, o;
    logic [3:0]  ops[4] = '{14, 0, 0, 2};
    logic [15:0] ds[4]  = '{0, 16'h0003, 16'h0004, 0};
    int unsigned idx = 0, ndone = 0, gaps = 0;
    int          last = -1;
    cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 40 && ndone < 4; cyc++) begin
      @(negedge clk);
      if (done) begin
        o.ok = 1'b1; o.top = top; o.next = next; o.count = count; o.err = err;
        obs_q.push_back(o);
        if (last >= 0 && cyc - last != 2) gaps++;
        last = cyc;
        ndone++;
      end
      if (cmd_ready) begin
        if (idx < 4) begin
          cmd_valid = 1'b1; cmd_op = ops[idx]; cmd_data = ds[idx];
          model_push(ops[idx], ds[idx]);
          idx++;
        end else cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    n_cmp++; if (ndone != 4) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 4", ndone); end
    n_cmp++; if (gaps != 0) begin n_bad++; $display("FAIL b2b_spacing: got %0d bad gaps want 0", gaps); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL b2b: got %p want %p", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu();
    test_stack_ops();
    test_bounds();
    test_illegal_mul();
    test_reset_exec();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
